regfile_sb: RTL and testbench

Parametrised multi-read-port integer register file with a built-in pending-write scoreboard, for the pipelined RISC-V core. Decode reads operands and sees per-operand busy flags; issue marks the destination register as pending; writeback stores the result and retires the pending mark. Write-to-read bypass and a hardwired-zero x0 are kept, so the pipeline needs no separate hazard table for register dependencies.

---
 rtl/regfile_sb_pkg.sv | 17 +
 rtl/regfile_sb_cnt.sv | 37 +++
 rtl/regfile_sb.sv | 131 +++++++++++++
 tb/tb_regfile_sb.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared defaults and helpers for the integer register file with pending-write scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF  = 32'd32;
  localparam int NREGS_DEF = 32'd32;
  localparam int X0_IDX    = 32'd0;

  // Address width for a register count, never below one bit.
  function automatic int calc_aw(input int n);
    if (n <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/regfile_sb_cnt.sv
// One pending-write counter: issue increments, retire decrements, neither wraps.
module regfile_sb_cnt #(
  parameter int CNTW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            dec,
  output logic [CNTW-1:0] cnt,
  output logic            full,
  output logic            underflow
);

  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1'b1);
  localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

  logic [CNTW-1:0] cnt_r;

  // Counter update; simultaneous inc and dec is a net zero change.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (inc && !dec && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else if (dec && !inc && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt       = cnt_r;
  assign full      = (cnt_r == CNT_MAX);
  assign underflow = dec && (cnt_r == CNT_ZERO);

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with per-register pending-write counters,
// writeback bypass and hardwired-zero x0.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int CNTW   = 2,
  parameter int BYPASS = 1,
  localparam int AW    = calc_aw(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ready,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  output logic                sb_err
);

  localparam logic [AW-1:0]   X0_ADDR  = AW'(X0_IDX);
  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1'b1);

  logic [XLEN-1:0] data_s [NREGS];
  logic [CNTW-1:0] cnt_s  [NREGS];
  logic            full_s [NREGS];
  logic            uf_s   [NREGS];
  logic            uf_any_s;
  logic            sb_err_r;

  assign data_s[0] = {XLEN{1'b0}};
  assign cnt_s[0]  = CNT_ZERO;
  assign full_s[0] = 1'b0;
  assign uf_s[0]   = 1'b0;

  // A writeback to a full register frees a slot in the same cycle.
  assign iss_ready = (iss_rd == X0_ADDR) || !full_s[iss_rd] ||
                     (wr_en && (wr_addr == iss_rd));

  for (genvar i = 1; i < NREGS; i++) begin : g_reg
    logic [XLEN-1:0] data_r;
    logic            wr_hit_s;
    logic            iss_hit_s;

    assign wr_hit_s  = wr_en && (wr_addr == AW'(i));
    assign iss_hit_s = iss_en && iss_ready && (iss_rd == AW'(i));

    // Architectural register storage.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_r <= {XLEN{1'b0}};
      end else if (wr_hit_s) begin
        data_r <= wr_data;
      end else begin
        data_r <= data_r;
      end
    end

    regfile_sb_cnt #(
      .CNTW (CNTW)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (iss_hit_s),
      .dec       (wr_hit_s),
      .cnt       (cnt_s[i]),
      .full      (full_s[i]),
      .underflow (uf_s[i])
    );

    assign data_s[i] = data_r;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr_s;
    logic            byp_s;
    logic [XLEN-1:0] data_k_s;
    logic            busy_k_s;

    assign addr_s = rd_addr[k*AW +: AW];
    assign byp_s  = (BYPASS != 0) && wr_en && (wr_addr == addr_s);

    // Operand select; a forwarded retire of the last pending write clears busy.
    always_comb begin
      data_k_s = data_s[addr_s];
      busy_k_s = (cnt_s[addr_s] != CNT_ZERO);
      if (addr_s == X0_ADDR) begin
        data_k_s = {XLEN{1'b0}};
        busy_k_s = 1'b0;
      end else if (byp_s) begin
        data_k_s = wr_data;
        busy_k_s = (cnt_s[addr_s] > CNT_ONE);
      end else begin
        data_k_s = data_s[addr_s];
        busy_k_s = (cnt_s[addr_s] != CNT_ZERO);
      end
    end

    assign rd_data[k*XLEN +: XLEN] = data_k_s;
    assign rd_busy[k]              = busy_k_s;
  end

  // Reduce per-register underflow flags.
  always_comb begin
    uf_any_s = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      uf_any_s = uf_any_s | uf_s[i];
    end
  end

  // Sticky scoreboard error.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err_r <= 1'b0;
    end else if (uf_any_s) begin
      sb_err_r <= 1'b1;
    end else begin
      sb_err_r <= sb_err_r;
    end
  end

  assign sb_err = sb_err_r;

endmodule

// File: tb/tb_regfile_sb.sv
// Table-driven bench for regfile_sb: a BYPASS=1 and a BYPASS=0 instance share stimulus.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int CNTW  = 2;
  localparam int AW    = 5;

  typedef struct {
    logic          chk;
    logic          rst;
    logic          we;
    logic [AW-1:0] wa;
    logic [31:0]   wd;
    logic          ie;
    logic [AW-1:0] ir;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [31:0]   d0;
    logic [31:0]   d1;
    logic          b0;
    logic          b1;
    logic          rdy;
    logic          err;
    logic [31:0]   nd0;
    logic          nb0;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data, rd_data_nb;
  logic [NRD-1:0]      rd_busy, rd_busy_nb;
  logic                iss_en, iss_ready, iss_ready_nb;
  logic [AW-1:0]       iss_rd;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                sb_err, sb_err_nb;

  int   errors = 0;
  int   checks = 0;
  int   row_no = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .CNTW(CNTW), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_en(iss_en), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_err(sb_err)
  );

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .CNTW(CNTW), .BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .iss_en(iss_en), .iss_rd(iss_rd), .iss_ready(iss_ready_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_err(sb_err_nb)
  );

  function automatic vec_t mk(
    input logic chk, input logic rs, input logic we, input logic [AW-1:0] wa,
    input logic [31:0] wd, input logic ie, input logic [AW-1:0] ir,
    input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
    input logic [31:0] d0, input logic [31:0] d1, input logic b0, input logic b1,
    input logic rdy, input logic err, input logic [31:0] nd0, input logic nb0);
    vec_t v;
    v.chk = chk; v.rst = rs; v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ir = ir;
    v.ra0 = ra0; v.ra1 = ra1; v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1;
    v.rdy = rdy; v.err = err; v.nd0 = nd0; v.nb0 = nb0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row %0d %s: got %h expected %h", row_no, name, act, exp);
    end
  endtask

  task automatic check_out();
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL row %0d scoreboard: got empty queue expected an entry", row_no);
    end else begin
      e = exp_q.pop_front();
      if (e.chk) begin
        chk("rd_data0",    rd_data[31:0],             e.d0);
        chk("rd_data1",    rd_data[63:32],            e.d1);
        chk("rd_busy0",    {31'd0, rd_busy[0]},       {31'd0, e.b0});
        chk("rd_busy1",    {31'd0, rd_busy[1]},       {31'd0, e.b1});
        chk("iss_ready",   {31'd0, iss_ready},        {31'd0, e.rdy});
        chk("sb_err",      {31'd0, sb_err},           {31'd0, e.err});
        chk("nb_rd_data0", rd_data_nb[31:0],          e.nd0);
        chk("nb_rd_busy0", {31'd0, rd_busy_nb[0]},    {31'd0, e.nb0});
        chk("nb_iss_ready",{31'd0, iss_ready_nb},     {31'd0, e.rdy});
        chk("nb_sb_err",   {31'd0, sb_err_nb},        {31'd0, e.err});
      end
    end
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    row_no++;
    rst     = v.rst;
    wr_en   = v.we;
    wr_addr = v.wa;
    wr_data = v.wd;
    iss_en  = v.ie;
    iss_rd  = v.ir;
    rd_addr = {v.ra1, v.ra0};
    exp_q.push_back(v);
    #4;
    check_out();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_rd = '0; rd_addr = '0;
    repeat (2) @(posedge clk);

    // Post-reset sweep of every address on both ports.
    for (int a = 0; a < NREGS; a += 2) begin
      tbl.push_back(mk(1, 0, 0, 5'd0, 32'h0, 0, 5'(a), 5'(a), 5'(a + 1),
                       32'h0, 32'h0, 0, 0, 1, 0, 32'h0, 0));
    end
    // Write bypass and x0.
    tbl.push_back(mk(1,0, 0,5'd0,32'h0,        1,5'd5, 5'd5,5'd0, 32'h0,32'h0,               0,0, 1,0, 32'h0,0));
    tbl.push_back(mk(1,0, 1,5'd5,32'hDEADBEEF, 0,5'd0, 5'd5,5'd5, 32'hDEADBEEF,32'hDEADBEEF, 0,0, 1,0, 32'h0,1));
    tbl.push_back(mk(1,0, 0,5'd0,32'h0,        0,5'd0, 5'd5,5'd0, 32'hDEADBEEF,32'h0,        0,0, 1,0, 32'hDEADBEEF,0));
    tbl.push_back(mk(1,0, 1,5'd0,32'h1234,     0,5'd0, 5'd0,5'd5, 32'h0,32'hDEADBEEF,        0,0, 1,0, 32'h0,0));
    tbl.push_back(mk(1,0, 0,5'd0,32'h0,        0,5'd0, 5'd0,5'd5, 32'h0,32'hDEADBEEF,        0,0, 1,0, 32'h0,0));
    // Counter saturation on x7, then issue+retire at max.
    tbl.push_back(mk(1,0, 0,5'd0,32'h0,        1,5'd7, 5'd7,5'd0, 32'h0,32'h0,               0,0, 1,0, 32'h0,0));
    tbl.push_back(mk(1,0, 0,5'd0,32'h0,        1,5'd7, 5'd7,5'd0, 32'h0,32'h0,               1,0, 1,0, 32'h0,1));
    tbl.push_back(mk(1,0, 0,5'd0,32'h0,        1,5'd7, 5'd7,5'd0, 32'h0,32'h0,               1,0, 1,0, 32'h0,1));
    tbl.push_back(mk(1,0, 0,5'd0,32'h0,        1,5'd7, 5'd7,5'd0, 32'h0,32'h0,               1,0, 0,0, 32'h0,1));
    tbl.push_back(mk(1,0, 1,5'd7,32'h77,       1,5'd7, 5'd7,5'd0, 32'h77,32'h0,              1,0, 1,0, 32'h0,1));
    tbl.push_back(mk(1,0, 0,5'd0,32'h0,        0,5'd7, 5'd7,5'd0, 32'h77,32'h0,              1,0, 0,0, 32'h77,1));
    tbl.push_back(mk(1,0, 1,5'd7,32'h70,       0,5'd0, 5'd7,5'd0, 32'h70,32'h0,              1,0, 1,0, 32'h77,1));
    tbl.push_back(mk(1,0, 1,5'd7,32'h71,       0,5'd0, 5'd7,5'd0, 32'h71,32'h0,              1,0, 1,0, 32'h70,1));
    tbl.push_back(mk(1,0, 1,5'd7,32'h72,       0,5'd0, 5'd7,5'd0, 32'h72,32'h0,              0,0, 1,0, 32'h71,1));
    tbl.push_back(mk(1,0, 0,5'd0,32'h0,        0,5'd7, 5'd7,5'd0, 32'h72,32'h0,              0,0, 1,0, 32'h72,0));
    // Issue then retire x3 with a same-cycle read.
    tbl.push_back(mk(1,0, 0,5'd0,32'h0,        1,5'd3, 5'd3,5'd0, 32'h0,32'h0,               0,0, 1,0, 32'h0,0));
    tbl.push_back(mk(1,0, 1,5'd3,32'h55,       0,5'd0, 5'd3,5'd0, 32'h55,32'h0,              0,0, 1,0, 32'h0,1));
    tbl.push_back(mk(1,0, 0,5'd0,32'h0,        0,5'd0, 5'd3,5'd0, 32'h55,32'h0,              0,0, 1,0, 32'h55,0));
    // Retire x9 with nothing pending.
    tbl.push_back(mk(1,0, 1,5'd9,32'h99,       0,5'd0, 5'd9,5'd0, 32'h99,32'h0,              0,0, 1,0, 32'h0,0));
    tbl.push_back(mk(1,0, 0,5'd0,32'h0,        0,5'd0, 5'd9,5'd5, 32'h99,32'hDEADBEEF,       0,0, 1,1, 32'h99,0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end

    // sb_err stays set across idle cycles.
    for (int i = 0; i < 3; i++) begin
      apply(mk(1,0, 0,5'd0,32'h0, 0,5'd0, 5'd7,5'd3, 32'h72,32'h55, 0,0, 1,1, 32'h72,0));
    end

    // Reset with x4 in flight and a concurrent writeback to x4.
    apply(mk(1,0, 0,5'd0,32'h0,  1,5'd4, 5'd4,5'd0, 32'h0,32'h0, 0,0, 1,1, 32'h0,0));
    apply(mk(1,0, 0,5'd0,32'h0,  1,5'd4, 5'd4,5'd0, 32'h0,32'h0, 1,0, 1,1, 32'h0,1));
    apply(mk(0,1, 1,5'd4,32'hAA, 1,5'd4, 5'd4,5'd0, 32'h0,32'h0, 0,0, 1,0, 32'h0,0));
    apply(mk(1,0, 0,5'd0,32'h0,  0,5'd4, 5'd4,5'd9, 32'h0,32'h0, 0,0, 1,0, 32'h0,0));
    apply(mk(1,0, 0,5'd0,32'h0,  0,5'd7, 5'd7,5'd5, 32'h0,32'h0, 0,0, 1,0, 32'h0,0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
